// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 text sequencer.
//   - lcd_state_e : sequencer FSM states
//   - LCD_CMD_*   : HD44780 command bytes used by the sequencer
//   - LCD_CHAR_SPACE : blank character used to clear the frame buffer
//   - init_cmd()  : maps the init step index (0..3) to its command byte
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_INIT     = 3'd1,
        ST_CLR_WAIT = 3'd2,
        ST_LINE1    = 3'd3,
        ST_CHARS1   = 3'd4,
        ST_LINE2    = 3'd5,
        ST_CHARS2   = 3'd6,
        ST_IDLE     = 3'd7
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;  // increment, no shift
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;  // clear display (slow command)
    localparam logic [7:0] LCD_CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] LCD_CMD_LINE2    = 8'hC0;  // DDRAM address 0x40
    localparam logic [7:0] LCD_CHAR_SPACE   = 8'h20;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_CMD_FUNC_SET;
            2'd1:    cmd = LCD_CMD_DISP_ON;
            2'd2:    cmd = LCD_CMD_ENTRY;
            2'd3:    cmd = LCD_CMD_CLEAR;
            default: cmd = LCD_CMD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// 32 x 8 character frame buffer for a 2x16 text display.
// Ports: clk, rst (sync, active-high, fills buffer with spaces),
//        wr_en/wr_addr/wr_data (synchronous write port),
//        rd_addr/rd_data (combinational read port).
module lcd_frame_buf
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem_r [32];

    // Reset blanks every position; writes are accepted on any non-reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_r[i] <= LCD_CHAR_SPACE;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/lcd_text_sequencer.sv
// HD44780 text sequencer: powers up and initialises the display, then streams
// the 32-character frame buffer (line 1 then line 2) on each refresh.
// Ports: clk, rst (sync, active-high), wr_en/wr_addr/wr_data (frame buffer
//        write), refresh_req (one-cycle refresh request), cmd_valid/cmd_ready
//        (byte handshake), cmd_rs (0 command, 1 data), cmd_data, busy.
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int CLR_WAIT_CYC  = 100000,
    parameter int INIT_WAIT_CYC = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh_req,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    output logic       busy
);

    localparam int PW = $clog2(INIT_WAIT_CYC) + 1;
    localparam int CW = $clog2(CLR_WAIT_CYC) + 1;
    // Last count value before leaving a wait state; a zero wait still spends
    // exactly one cycle in the state.
    localparam logic [PW-1:0] PWR_LAST = (INIT_WAIT_CYC == 0) ? PW'(0) : PW'(INIT_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = (CLR_WAIT_CYC == 0) ? CW'(0) : CW'(CLR_WAIT_CYC - 1);
    localparam logic [PW-1:0] PW_ONE   = PW'(1);
    localparam logic [CW-1:0] CW_ONE   = CW'(1);

    lcd_state_e    state_r;
    logic [PW-1:0] pwr_cnt_r;
    logic [CW-1:0] clr_cnt_r;
    logic [1:0]    init_idx_r;
    logic [3:0]    char_idx_r;
    logic          pending_r;
    logic          cmd_valid_r;
    logic          cmd_rs_r;
    logic [7:0]    cmd_data_r;
    logic          busy_r;
    logic          accept_s;
    logic [4:0]    rd_addr_s;
    logic [7:0]    rd_data_s;

    assign accept_s = cmd_valid_r & cmd_ready;

    // Address of the character that will be offered after the current accept.
    always_comb begin
        rd_addr_s = 5'd0;
        case (state_r)
            ST_LINE1:  rd_addr_s = 5'd0;
            ST_CHARS1: rd_addr_s = {1'b0, char_idx_r + 4'd1};
            ST_LINE2:  rd_addr_s = 5'd16;
            ST_CHARS2: rd_addr_s = {1'b1, char_idx_r + 4'd1};
            default:   rd_addr_s = 5'd0;
        endcase
    end

    lcd_frame_buf u_frame_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Sequencer FSM; the output byte is loaded on the edge it is first offered
    // and held untouched until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_PWR_WAIT;
            pwr_cnt_r   <= '0;
            clr_cnt_r   <= '0;
            init_idx_r  <= 2'd0;
            char_idx_r  <= 4'd0;
            pending_r   <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_rs_r    <= 1'b0;
            cmd_data_r  <= 8'h00;
            busy_r      <= 1'b1;
        end else begin
            if (refresh_req && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_PWR_WAIT: begin
                    if (pwr_cnt_r == PWR_LAST) begin
                        state_r     <= ST_INIT;
                        init_idx_r  <= 2'd0;
                        cmd_valid_r <= 1'b1;
                        cmd_rs_r    <= 1'b0;
                        cmd_data_r  <= init_cmd(2'd0);
                    end else begin
                        pwr_cnt_r <= pwr_cnt_r + PW_ONE;
                    end
                end
                ST_INIT: begin
                    if (accept_s) begin
                        if (init_idx_r == 2'd3) begin
                            state_r     <= ST_CLR_WAIT;
                            clr_cnt_r   <= '0;
                            cmd_valid_r <= 1'b0;
                        end else begin
                            init_idx_r <= init_idx_r + 2'd1;
                            cmd_data_r <= init_cmd(init_idx_r + 2'd1);
                        end
                    end
                end
                ST_CLR_WAIT: begin
                    if (clr_cnt_r == CLR_LAST) begin
                        state_r     <= ST_LINE1;
                        pending_r   <= 1'b0;
                        cmd_valid_r <= 1'b1;
                        cmd_rs_r    <= 1'b0;
                        cmd_data_r  <= LCD_CMD_LINE1;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + CW_ONE;
                    end
                end
                ST_LINE1: begin
                    if (accept_s) begin
                        state_r    <= ST_CHARS1;
                        char_idx_r <= 4'd0;
                        cmd_rs_r   <= 1'b1;
                        cmd_data_r <= rd_data_s;
                    end
                end
                ST_CHARS1: begin
                    if (accept_s) begin
                        // Index wraps 15 -> 0 naturally, ready for line 2.
                        char_idx_r <= char_idx_r + 4'd1;
                        if (char_idx_r == 4'd15) begin
                            state_r    <= ST_LINE2;
                            cmd_rs_r   <= 1'b0;
                            cmd_data_r <= LCD_CMD_LINE2;
                        end else begin
                            cmd_data_r <= rd_data_s;
                        end
                    end
                end
                ST_LINE2: begin
                    if (accept_s) begin
                        state_r    <= ST_CHARS2;
                        char_idx_r <= 4'd0;
                        cmd_rs_r   <= 1'b1;
                        cmd_data_r <= rd_data_s;
                    end
                end
                ST_CHARS2: begin
                    if (accept_s) begin
                        char_idx_r <= char_idx_r + 4'd1;
                        if (char_idx_r == 4'd15) begin
                            state_r     <= ST_IDLE;
                            cmd_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                        end else begin
                            cmd_data_r <= rd_data_s;
                        end
                    end
                end
                ST_IDLE: begin
                    if (refresh_req || pending_r) begin
                        state_r     <= ST_LINE1;
                        pending_r   <= 1'b0;
                        busy_r      <= 1'b1;
                        cmd_valid_r <= 1'b1;
                        cmd_rs_r    <= 1'b0;
                        cmd_data_r  <= LCD_CMD_LINE1;
                    end
                end
                default: begin
                    state_r     <= ST_PWR_WAIT;
                    pwr_cnt_r   <= '0;
                    cmd_valid_r <= 1'b0;
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_valid = cmd_valid_r;
    assign cmd_rs    = cmd_rs_r;
    assign cmd_data  = cmd_data_r;
    assign busy      = busy_r;

endmodule

// File: doc/lcd_text_sequencer.md
LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

Interface
REQ-001 SHALL have parameter CLR_WAIT_CYC, default 100000, meaning idle cycles after the clear-display command (2 ms at 50 MHz).
REQ-002 SHALL have parameter INIT_WAIT_CYC, default 2500000, meaning power-up wait before the first command (50 ms at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 wr_en  input  1  frame-buffer write strobe.
REQ-006 wr_addr  input  5  character position; 0-15 is line 1, 16-31 is line 2.
REQ-007 wr_data  input  8  ASCII character code.
REQ-008 refresh_req  input  1  single-cycle request to stream the frame buffer to the display.
REQ-009 cmd_valid  output  1  a byte is offered downstream to the LCD bus writer.
REQ-010 cmd_ready  input  1  the downstream writer accepts the byte this cycle.
REQ-011 cmd_rs  output  1  register select: 0 is command, 1 is data.
REQ-012 cmd_data  output  8  byte for the LCD DB7..DB0 bus.
REQ-013 busy  output  1  the sequence is in progress (not IDLE).

Function
REQ-014 Handshake: transfer occurs when cmd_valid=1 and cmd_ready=1 on the same clk edge.
- cmd_rs and cmd_data SHALL hold stable while cmd_valid=1 without cmd_ready.
- cmd_valid SHALL NOT drop until the byte is accepted.
REQ-015 After each transfer, the next byte SHALL be offered on the following cycle unless a wait state intervenes, giving one byte per cycle maximum.
REQ-016 FSM states and transitions:
- PWR_WAIT: count INIT_WAIT_CYC cycles, then go to INIT.
- INIT: send 0x38, 0x0C, 0x06, 0x01 with rs=0, in that order; after 0x01 is accepted, go to CLR_WAIT.
- CLR_WAIT: count CLR_WAIT_CYC cycles, then go to LINE1 (automatic first refresh).
- LINE1: send 0x80 with rs=0, then go to CHARS1.
- CHARS1: send buffer[0..15] with rs=1, then go to LINE2.
- LINE2: send 0xC0 with rs=0, then go to CHARS2.
- CHARS2: send buffer[16..31] with rs=1, then go to IDLE.
- IDLE: go to LINE1 when refresh_req=1 or a refresh is pending.
REQ-017 The frame buffer SHALL be 32 x 8 bits and written on any cycle with wr_en=1, including while busy.
REQ-018 A character SHALL be sampled into cmd_data when it is first offered.
- A write to that address while the byte is stalled SHALL NOT alter cmd_data.
- Such a write SHALL appear on the next refresh.
REQ-019 refresh_req in any state other than IDLE SHALL set a single pending flag.
- Multiple requests SHALL collapse to one.
- The pending flag SHALL be cleared on entry to LINE1.
REQ-020 refresh_req in IDLE SHALL cause cmd_valid=1 with 0x80 on the next cycle.
REQ-021 The character index counter SHALL be 4 bits and wrap 15 -> 0 at each line end; the line is selected by FSM state.
REQ-022 Wait counters SHALL be sized as $clog2 of the parameter plus 1.
- A parameter value of 0 SHALL mean zero wait cycles, so the next state is entered on the next cycle.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 On rst=1 at a clk edge, the block SHALL:
- enter PWR_WAIT with all counters cleared;
- set cmd_valid=0, cmd_rs=0, cmd_data=0x00 and busy=1;
- clear the pending flag;
- fill all 32 buffer entries with 0x20 (space).
REQ-025 Reset asserted mid-transfer SHALL drop cmd_valid on the next cycle and SHALL restart the full power-up sequence; no partial sequence resumes.
REQ-026 wr_en and refresh_req SHALL be ignored while rst=1.

Structure
REQ-027 A shared package lcd_pkg SHALL hold:
- the FSM state enumeration;
- the HD44780 command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0);
- the space-character constant.
REQ-028 The frame buffer SHALL be a natural sub-module, lcd_frame_buf, with a 32x8 register array, one synchronous write port and one combinational read port.

Verification
REQ-029 Power-up with CLR_WAIT_CYC=4, INIT_WAIT_CYC=8 and cmd_ready=1:
- after 8 cycles, 38,0C,06,01 are sent with rs=0;
- after 4 more cycles, 80, 16x20, C0, 16x20 are sent;
- busy then falls.
REQ-030 Write "FPGA" at addresses 0-3 and "GOOD!!" at 16-21, then pulse refresh_req in IDLE:
- the sequence is 80,'F','P','G','A', 12x20, C0,'G','O','O','D','!','!', 10x20;
- rs matches per byte.
REQ-031 Hold cmd_ready=0 for 5 cycles on character 3, and write address 3 during the stall:
- cmd_data stays at the old value until accepted;
- the new value appears on the next refresh.
REQ-032 Pulse refresh_req three times during CHARS1:
- exactly one additional full pass follows, starting with 0x80 on the cycle after IDLE is reached.
REQ-033 Assert rst during CHARS2:
- cmd_valid=0 on the next cycle;
- the buffer reads back as all 0x20;
- the 0x38 init sequence restarts after INIT_WAIT_CYC.
